// File: rtl/vt_loader_pkg.sv
// vt_loader_pkg: shared FSM encoding and LFSR constants for the variable-table loader
package vt_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_TAPS         = 32'h80200003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h1;

endpackage

// File: rtl/vt_lfsr32.sv
// vt_lfsr32: 32-bit Fibonacci LFSR (taps 32,22,2,1) with seed load and advance enable
module vt_lfsr32
    import vt_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_i,
    output logic        bit_o
);

    logic [31:0] lfsr_q, lfsr_d;

    // Load wins over advance; an all-zero seed would lock the register, so it is replaced
    always_comb begin
        lfsr_d = load_i ? ((seed_i == '0) ? LFSR_DEFAULT_SEED : seed_i)
               : adv_i  ? {^(lfsr_q & LFSR_TAPS), lfsr_q[31:1]}
               : lfsr_q;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_DEFAULT_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/variable_table_loader.sv
// variable_table_loader: unpacks host assignment words LSB-first into one broadcast table write per cycle
// Optional LFSR fill mode (rand_mode_i, seed_i) is built when VT_LFSR_INIT_EN is defined.
module variable_table_loader
    import vt_loader_pkg::*;
#(
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int WORD_WIDTH             = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic [VARIABLE_ADDRESS_WIDTH:0]   num_vars_i,
`ifdef VT_LFSR_INIT_EN
    input  logic                              rand_mode_i,
    input  logic [31:0]                       seed_i,
`endif
    input  logic                              word_valid_i,
    output logic                              word_ready_o,
    input  logic [WORD_WIDTH-1:0]             word_data_i,
    output logic                              axi_en_o,
    output logic                              axi_wr_en_o,
    output logic [VARIABLE_ADDRESS_WIDTH-1:0] axi_addr_o,
    output logic                              axi_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int AW = VARIABLE_ADDRESS_WIDTH;
    localparam int CW = AW + 1;
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] MAX_CNT  = {1'b1, {AW{1'b0}}};
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic                  mode_q, mode_d;
    logic                  start_mode, wr, last, data_bit;
    logic [CW-1:0]         num_clamped;

    assign num_clamped = (num_vars_i > MAX_CNT) ? MAX_CNT : num_vars_i;
    assign wr          = (state_q == WRITE);
    assign last        = ({1'b0, addr_q} == cnt_q - CW'(1));

`ifdef VT_LFSR_INIT_EN
    logic lfsr_bit;

    assign start_mode = rand_mode_i;
    assign data_bit   = mode_q ? lfsr_bit : sr_q[0];

    vt_lfsr32 u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (state_q == IDLE && start_i && !abort_i),
        .seed_i (seed_i),
        .adv_i  (wr),
        .bit_o  (lfsr_bit)
    );
`else
    assign start_mode = 1'b0;
    assign data_bit   = sr_q[0];
`endif

    // Next-state logic; abort overrides everything and simply returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        mode_d  = mode_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    cnt_d   = num_clamped;
                    addr_d  = '0;
                    mode_d  = start_mode;
                    state_d = (num_clamped == '0) ? DONE : start_mode ? WRITE : FETCH;
                end
                FETCH: if (word_valid_i) begin
                    sr_d    = word_data_i;
                    bit_d   = '0;
                    state_d = WRITE;
                end
                WRITE: begin
                    sr_d    = sr_q >> 1;
                    addr_d  = addr_q + AW'(1);
                    bit_d   = bit_q + BW'(1);
                    state_d = last ? DONE : (!mode_q && bit_q == BIT_LAST) ? FETCH : WRITE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            mode_q  <= mode_d;
        end
    end

    assign word_ready_o = (state_q == FETCH);
    assign axi_en_o     = wr;
    assign axi_wr_en_o  = wr;
    assign axi_addr_o   = wr ? addr_q : '0;
    assign axi_data_o   = wr & data_bit;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_variable_table_loader.sv
// tb_variable_table_loader: randomized self-checking bench against a list-based write model
module tb_variable_table_loader;

    localparam int AW = 11;
    localparam int WW = 32;
    localparam int MAXN = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW:0]   num_vars_i = '0;
    logic          word_valid_i = 1'b0;
    logic [WW-1:0] word_data_i = '0;
    logic          word_ready_o, axi_en_o, axi_wr_en_o, axi_data_o, busy_o, done_o;
    logic [AW-1:0] axi_addr_o;
`ifdef VT_LFSR_INIT_EN
    logic          rand_mode_i = 1'b0;
    logic [31:0]   seed_i = '0;
`endif

    variable_table_loader #(.VARIABLE_ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .num_vars_i   (num_vars_i),
`ifdef VT_LFSR_INIT_EN
        .rand_mode_i  (rand_mode_i),
        .seed_i       (seed_i),
`endif
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .word_data_i  (word_data_i),
        .axi_en_o     (axi_en_o),
        .axi_wr_en_o  (axi_wr_en_o),
        .axi_addr_o   (axi_addr_o),
        .axi_data_o   (axi_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wa[$];
    logic          wd[$];
    int            wc[$];
    int            n_done, done_cyc, n_busy, n_ready, we_bad;
    logic [WW-1:0] words[$];

    // Observed bus activity, sampled mid-cycle
    always @(negedge clk) begin
        if (axi_en_o) begin
            wa.push_back(axi_addr_o);
            wd.push_back(axi_data_o);
            wc.push_back(cyc);
        end
        if (axi_en_o !== axi_wr_en_o) we_bad++;
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy_o) n_busy++;
        if (word_ready_o) n_ready++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete(); wd.delete(); wc.delete();
        n_done = 0; done_cyc = -1; n_busy = 0; n_ready = 0; we_bad = 0;
    endtask

    task automatic start_load(input int n);
        @(posedge clk); #1;
        start_i = 1'b1;
        num_vars_i = (AW+1)'(n);
        start_cyc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic fill_words(input int nw, input int kind);
        words.delete();
        for (int j = 0; j < nw; j++) words.push_back(kind == 1 ? '1 : WW'($urandom));
    endtask

    // Host side: offers each word, optionally holding one back sn cycles after FETCH is entered
    task automatic feed(input int nw, input int sw, input int sn);
        for (int j = 0; j < nw; j++) begin
            int  t = 0;
            bit  acc = 1'b0;
            word_valid_i = 1'b0;
            if (j == sw) begin
                while (!word_ready_o && t < 200) begin @(posedge clk); #1; t++; end
                repeat (sn) begin @(posedge clk); #1; end
            end
            word_valid_i = 1'b1;
            word_data_i = words[j];
            t = 0;
            do begin
                @(negedge clk);
                acc = word_ready_o;
                @(posedge clk); #1;
                t++;
            end while (!acc && t < 200);
            if (!acc) begin
                check("handshake_timeout", 0, 1);
                break;
            end
        end
        word_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (n_done == 0 && t < 5000) begin @(posedge clk); #1; t++; end
        if (n_done == 0) check("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: write i goes to address i with bit (i mod 32) of word i/32; one FETCH cycle per word
    task automatic verify(input string tag, input int n, input int sw, input int sn);
        int exp_n = (n > MAXN) ? MAXN : n;
        int nw = (exp_n + WW - 1) / WW;
        int exp_busy = nw + exp_n + 1 + ((sw >= 0 && sw < nw) ? sn : 0);
        check({tag, "_count"}, wa.size(), exp_n);
        check({tag, "_done_n"}, n_done, 1);
        check({tag, "_busy"}, n_busy, exp_busy);
        check({tag, "_done_cyc"}, done_cyc, start_cyc + exp_busy);
        check({tag, "_we"}, we_bad, 0);
        for (int i = 0; i < exp_n && i < wa.size(); i++) begin
            logic [WW-1:0] w = words[i / WW];
            int gap = (i % WW == 0) ? 2 + ((i / WW == sw) ? sn : 0) : 1;
            check({tag, "_addr"}, wa[i], i);
            check({tag, "_data"}, wd[i], w[i % WW]);
            if (i > 0) check({tag, "_gap"}, wc[i] - wc[i-1], gap);
            else check({tag, "_first"}, wc[0], start_cyc + gap);
        end
    endtask

    task automatic host_load(input string tag, input int n, input int sw, input int sn);
        int exp_n = (n > MAXN) ? MAXN : n;
        clear_mon();
        start_load(n);
        feed((exp_n + WW - 1) / WW, sw, sn);
        wait_done();
        verify(tag, n, sw, sn);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", axi_en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", word_ready_o, 0);
        check("rst_done", done_o, 0);
        check("rst_addr", axi_addr_o, 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        // Two host words with one FETCH bubble; a start pulse mid-load must be ignored
        clear_mon();
        words.delete();
        words.push_back(32'hA5A5A5A5);
        words.push_back(32'h000000FF);
        start_load(40);
        fork
            begin
                repeat (12) @(posedge clk);
                #1 start_i = 1'b1; num_vars_i = 12'd5;
                @(posedge clk);
                #1 start_i = 1'b0;
            end
        join_none
        feed(2, -1, 0);
        wait_done();
        verify("n40", 40, -1, 0);

        // Zero-length load
        clear_mon();
        start_load(0);
        wait_done();
        verify("n0", 0, -1, 0);

        // Host stall before the second word
        fill_words(2, 0);
        host_load("stall", 64, 1, 10);

        // Abort while writing address 5, then reload from address 0
        begin
            int t = 0;
            clear_mon();
            fill_words(2, 0);
            start_load(64);
            word_valid_i = 1'b1;
            word_data_i = words[0];
            @(negedge clk);
            while (!(axi_en_o && axi_addr_o == 5) && t < 100) begin @(negedge clk); t++; end
            abort_i = 1'b1;
            @(posedge clk); #1;
            abort_i = 1'b0;
            word_valid_i = 1'b0;
            check("abort_busy", busy_o, 0);
            check("abort_en", axi_en_o, 0);
            repeat (5) @(posedge clk);
            #1;
            check("abort_writes", wa.size(), 6);
            check("abort_done", n_done, 0);
            fill_words(2, 0);
            host_load("reload", 40, -1, 0);
        end

        // Abort in FETCH with a word offered the same cycle: nothing accepted
        clear_mon();
        start_load(40);
        repeat (2) begin @(posedge clk); #1; end
        word_valid_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk); #1;
        word_valid_i = 1'b0;
        abort_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_fetch_writes", wa.size(), 0);
        check("abort_fetch_busy", busy_o, 0);
        check("abort_fetch_done", n_done, 0);

        // Abort together with start in IDLE
        clear_mon();
        @(posedge clk); #1;
        start_i = 1'b1; abort_i = 1'b1; num_vars_i = 12'd10;
        @(posedge clk); #1;
        start_i = 1'b0; abort_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_start_busy", n_busy, 0);

        // Randomized host loads
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 100);
            int nw = (n + WW - 1) / WW;
            fill_words(nw, 0);
            host_load("rand", n, $urandom_range(0, nw - 1), $urandom_range(0, 5));
        end

        // Full table and clamped oversize count
        fill_words(MAXN / WW, 1);
        host_load("full", MAXN, -1, 0);
        check("full_last_addr", wa.size() > 0 ? wa[wa.size()-1] : 0, MAXN - 1);
        fill_words(MAXN / WW, 0);
        host_load("clamp", 4095, -1, 0);

        // Reset mid-load drops outputs immediately
        clear_mon();
        fill_words(2, 0);
        start_load(64);
        word_valid_i = 1'b1;
        word_data_i = words[0];
        repeat (6) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_en", axi_en_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_addr", axi_addr_o, 0);
        word_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);

`ifdef VT_LFSR_INIT_EN
        begin
            logic [31:0] s = 32'h1;
            clear_mon();
            @(posedge clk); #1;
            start_i = 1'b1; num_vars_i = 12'd8; rand_mode_i = 1'b1; seed_i = '0;
            start_cyc = cyc;
            @(posedge clk); #1;
            start_i = 1'b0; rand_mode_i = 1'b0;
            wait_done();
            check("lfsr_ready", n_ready, 0);
            check("lfsr_count", wa.size(), 8);
            check("lfsr_done", n_done, 1);
            for (int i = 0; i < 8 && i < wa.size(); i++) begin
                check("lfsr_addr", wa[i], i);
                check("lfsr_data", wd[i], s[0]);
                check("lfsr_cyc", wc[i], start_cyc + 1 + i);
                s = {^(s & 32'h80200003), s[31:1]};
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
